csr_bram_loader: RTL and testbench
==================================

# csr_bram_loader

Writes a compiled regex automaton's CSR table into the 128-bit transition BRAM that `CSR_traversal` reads. A host byte stream arrives over a valid/ready handshake and is packed into 16-byte words, which are written to BRAM port B at consecutive addresses. The block holds the traversal engine in reset until the full table is loaded, and optionally until the table's checksum is verified.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: BRAM word address width; matches the engine's `rd_address`.
- `DATA_WIDTH`, 128: BRAM word width. Must be a multiple of 8. Bytes per word `BPW = DATA_WIDTH/8`.
- `BASE_ADDR`, 0: address of the first table word.

Ports:
- `clk`, in, 1: single clock, shared with the BRAM and the engine.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a load.
- `in_valid`, in, 1: host byte valid.
- `in_data`, in, 8: host byte.
- `in_ready`, out, 1: block accepts the byte this cycle.
- `wr_en`, out, 1: BRAM port B write strobe.
- `wr_addr`, out, `ADDR_WIDTH`: BRAM write address.
- `wr_data`, out, `DATA_WIDTH`: BRAM write word.
- `word_count`, out, 16: number of words written in the current load.
- `load_done`, out, 1: table loaded and valid. Level signal.
- `load_error`, out, 1: checksum mismatch. Level signal.
- `engine_reset`, out, 1: reset for `CSR_traversal`. High unless `load_done` is high.

## Operation
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `word_count`=0, `load_done`=0, `load_error`=0, `engine_reset`=1. State is IDLE.
- A byte transfers on any cycle where `in_valid` and `in_ready` are both high. `in_ready` is high only in HDR_LO, HDR_HI, DATA and CHECK. It does not depend on `in_valid`.
- Stream format: N low byte, N high byte, then N×`BPW` data bytes, then one checksum byte (CHECK state, macro-dependent only).
- States and transitions:
  - IDLE: on `start`, go to HDR_LO.
  - HDR_LO: on transfer, go to HDR_HI.
  - HDR_HI: on transfer, latch N. Go to DATA if N≠0; otherwise go to CHECK (macro on) or DONE (macro off).
  - DATA: accepts bytes until the last byte of word N−1, then goes to CHECK or DONE on the same rules.
  - CHECK: on transfer, go to DONE if the checksum matches, else ERROR.
  - DONE and ERROR: on `start`, go to HDR_LO.
- Leaving DONE or ERROR clears `load_done`, `load_error` and `word_count`, and forces `engine_reset`=1 on the next cycle.
- `start` is ignored in HDR_LO, HDR_HI, DATA and CHECK.
- Packing: within a word, byte k (k=0..`BPW`−1, in arrival order) goes to `wr_data[8k+7:8k]`, little-endian lanes.
- Word j is written to `wr_addr` = `BASE_ADDR`+j, truncated to `ADDR_WIDTH` bits. Wrap-around is allowed and is not flagged.
- `word_count` increments with each `wr_en` pulse. N=65535 is the maximum.
- DONE: `load_done`=1, `engine_reset`=0.
- ERROR: `load_error`=1, `engine_reset`=1. Words already written stay in the BRAM.
- Reset mid-load: return to IDLE next cycle with all outputs at reset values. A partially packed word is discarded and never written.

## Timing
- Sustained throughput: one byte per cycle, so one word every `BPW` cycles with `in_valid` held high. Gaps in `in_valid` stall packing but lose no data.
- The last byte of a word transfers at cycle T. At T+1, `wr_en`=1 for exactly one cycle with that word's `wr_addr` and `wr_data`. `word_count` reflects the new value at T+2.
- Macro off: the last data byte (or HDR_HI when N=0) transfers at T. `load_done` rises and `engine_reset` falls at T+2, after the final write.
- Macro on: the checksum byte transfers at T. `load_done` or `load_error` asserts at T+1.
- `start` in IDLE at cycle S: `in_ready`=1 at S+1.

## Configuration
- `CSR_LOADER_CHECKSUM_EN`, defined: the CHECK state exists. The checksum byte must equal the XOR of both header bytes and all data bytes. A mismatch enters ERROR.
- Undefined: no CHECK state and no checksum byte in the stream. `load_error` is tied to 0 and ERROR is unreachable.

## Test plan
- N=1, `BPW`=16, bytes 0x00..0x0F back-to-back: one `wr_en` at addr 0 with `wr_data`=0x0F0E0D0C0B0A09080706050403020100. `load_done`=1 two cycles after byte 0x0F (macro off).
- N=3 with random `in_valid` gaps: writes to addresses 0, 1, 2 in order. `word_count`=3. `engine_reset` is 1 throughout and falls after the third write.
- N=0 (header 0x00, 0x00): no `wr_en`. `load_done` asserts with `word_count`=0.
- Macro on, N=1 with a correct XOR byte: DONE. Repeat with the checksum byte flipped (XOR 0x01): `load_error`=1, `engine_reset` stays 1, the BRAM word is still written.
- `reset` asserted after 10 data bytes: outputs return to reset values next cycle and no `wr_en` occurs. A new `start` with N=1 then loads normally at addr 0.
- `start` pulsed in DATA is ignored. `start` in DONE clears `load_done` and raises `engine_reset` the next cycle, and the second load rewrites from `BASE_ADDR`.

Source files
------------

// File: rtl/csr_bram_loader.sv
// Packs a host byte stream (N lo, N hi, N*BPW data bytes) into BRAM words; CSR_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Write lands one cycle after a word's last byte; in_ready depends only on state, never on in_valid.
module csr_bram_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [15:0]           word_count,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  engine_reset
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

`ifdef CSR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR} state_t;
  localparam state_t POST_DATA = CHECK;
`else
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, DONE} state_t;
  localparam state_t POST_DATA = DONE;
`endif

  state_t                state, state_next;
  logic                  xfer;
  logic                  load_start;
  logic [7:0]            n_lo;
  logic [15:0]           n_words;
  logic [15:0]           pkt_words;
  logic [IW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] pack;
  logic [DATA_WIDTH-1:0] pack_merged;
`ifdef CSR_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign xfer         = in_valid & in_ready;
  assign engine_reset = ~load_done;

  // Current word with the incoming byte dropped into its lane, so the last byte can be written without waiting a cycle.
  always_comb begin
    pack_merged = pack;
    pack_merged[{byte_idx, 3'b000} +: 8] = in_data;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE:   if (start) state_next = HDR_LO;
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_next = HDR_HI;
      end
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ({in_data, n_lo} == 16'd0) ? POST_DATA : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_idx == LAST_IDX && pkt_words == n_words - 16'd1)
          state_next = POST_DATA;
      end
`ifdef CSR_LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (in_data == csum) ? DONE : ERROR;
      end
      ERROR:  if (start) state_next = HDR_LO;
`endif
      DONE:   if (start) state_next = HDR_LO;
      default: state_next = IDLE;
    endcase
    load_start = (state_next == HDR_LO) && (state != HDR_LO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n_lo       <= '0;
      n_words    <= '0;
      pkt_words  <= '0;
      byte_idx   <= '0;
      pack       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE;
      wr_data    <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef CSR_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state <= state_next;
      wr_en <= 1'b0;
      if (wr_en) begin
        wr_addr    <= wr_addr + 1'b1;
        word_count <= word_count + 16'd1;
      end
      if (xfer) begin
        case (state)
          HDR_LO: n_lo    <= in_data;
          HDR_HI: n_words <= {in_data, n_lo};
          DATA: begin
            pack <= pack_merged;
            if (byte_idx == LAST_IDX) begin
              byte_idx  <= '0;
              wr_en     <= 1'b1;
              wr_data   <= pack_merged;
              pkt_words <= pkt_words + 16'd1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          default: ;
        endcase
`ifdef CSR_LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
      end
      // A new load overrides any increment from a write still retiring from the previous one.
      if (load_start) begin
        wr_addr    <= BASE;
        word_count <= '0;
        pkt_words  <= '0;
        byte_idx   <= '0;
`ifdef CSR_LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end
`ifdef CSR_LOADER_CHECKSUM_EN
      load_done  <= (state_next == DONE);
      load_error <= (state_next == ERROR);
`else
      // Delay by one cycle so load_done rises only after the final word's write strobe.
      load_done  <= (state == DONE) && (state_next == DONE);
      load_error <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_csr_bram_loader.sv
// Directed bench for csr_bram_loader: expected BRAM writes queued as bytes are driven, popped on each wr_en.
module tb_csr_bram_loader;

  localparam int AW  = 16;
  localparam int DW  = 128;
  localparam int BPW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          tb_clk = 1'b0;
  logic          reset, start, in_valid, in_ready;
  logic [7:0]    in_data;
  logic          wr_en, load_done, load_error, engine_reset;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   word_count;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] xsum;

  always #5 tb_clk = ~tb_clk;

  csr_bram_loader dut (
    .clk(tb_clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .load_done(load_done),
    .load_error(load_error), .engine_reset(engine_reset)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tb_clk);
    #1;
  endtask

  // Every write strobe must match the oldest queued word.
  always @(posedge tb_clk) begin
    #1;
    if (wr_en) begin
      chk("write expected", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", DW'(wr_addr), DW'(mon_e.addr));
        chk("wr_data", wr_data, mon_e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bit done;
    in_valid = 1'b0;
    repeat (gap) cyc();
    in_valid = 1'b1;
    in_data  = b;
    xsum     = xsum ^ b;
    done     = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      done = in_ready;
      cyc();
    end
    chk("handshake", DW'(done), DW'(1));
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input int maxgap, input bit seq);
    logic [7:0]    b [BPW];
    logic [DW-1:0] w;
    wr_t           e;
    w = '0;
    for (int k = 0; k < BPW; k++) begin
      b[k] = seq ? 8'(k) : 8'($urandom_range(0, 255));
      w[8*k +: 8] = b[k];
    end
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < BPW; k++)
      send(b[k], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic start_load(input logic [15:0] n, input int maxgap);
    in_valid = 1'b0;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    chk("in_ready after start", DW'(in_ready), DW'(1));
    chk("load_done cleared", DW'(load_done), DW'(0));
    chk("engine_reset raised", DW'(engine_reset), DW'(1));
    chk("word_count cleared", DW'(word_count), DW'(0));
    xsum = 8'h00;
    send(n[7:0], maxgap);
    send(n[15:8], maxgap);
  endtask

  task automatic finish_ok(input logic [15:0] nwords);
`ifdef CSR_LOADER_CHECKSUM_EN
    send(xsum, 0);
    in_valid = 1'b0;
    chk("load_done at T+1", DW'(load_done), DW'(1));
    chk("load_error clear", DW'(load_error), DW'(0));
`else
    in_valid = 1'b0;
    chk("load_done low at T+1", DW'(load_done), DW'(0));
    chk("engine_reset high at T+1", DW'(engine_reset), DW'(1));
    cyc();
    chk("load_done at T+2", DW'(load_done), DW'(1));
`endif
    chk("engine_reset released", DW'(engine_reset), DW'(0));
    chk("word_count final", DW'(word_count), DW'(nwords));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst in_ready", DW'(in_ready), DW'(0));
    chk("rst wr_en", DW'(wr_en), DW'(0));
    chk("rst wr_addr", DW'(wr_addr), DW'(0));
    chk("rst wr_data", wr_data, DW'(0));
    chk("rst word_count", DW'(word_count), DW'(0));
    chk("rst load_done", DW'(load_done), DW'(0));
    chk("rst load_error", DW'(load_error), DW'(0));
    chk("rst engine_reset", DW'(engine_reset), DW'(1));

    // N=1, bytes 0x00..0x0F back-to-back
    start_load(16'd1, 0);
    send_word(16'd0, 0, 1'b1);
    chk("t1 wr_en at T+1", DW'(wr_en), DW'(1));
    chk("t1 wr_data", wr_data, 128'h0F0E0D0C0B0A09080706050403020100);
    finish_ok(16'd1);

    // N=3 with gaps; start pulsed mid-DATA must be ignored
    start_load(16'd3, 2);
    send_word(16'd0, 2, 1'b0);
    chk("t2 engine_reset w0", DW'(engine_reset), DW'(1));
    in_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start ignored in_ready", DW'(in_ready), DW'(1));
    chk("start ignored word_count", DW'(word_count), DW'(1));
    send_word(16'd1, 2, 1'b0);
    chk("t2 engine_reset w1", DW'(engine_reset), DW'(1));
    send_word(16'd2, 2, 1'b0);
    chk("t2 engine_reset w2", DW'(engine_reset), DW'(1));
    finish_ok(16'd3);

    // N=0: header only, no writes
    start_load(16'd0, 0);
    finish_ok(16'd0);

`ifdef CSR_LOADER_CHECKSUM_EN
    start_load(16'd1, 0);
    send_word(16'd0, 0, 1'b0);
    finish_ok(16'd1);
    start_load(16'd1, 0);
    send_word(16'd0, 0, 1'b0);
    send(xsum ^ 8'h01, 0);
    in_valid = 1'b0;
    chk("bad csum load_error", DW'(load_error), DW'(1));
    chk("bad csum load_done", DW'(load_done), DW'(0));
    chk("bad csum engine_reset", DW'(engine_reset), DW'(1));
    chk("bad csum word_count", DW'(word_count), DW'(1));
    cyc();
    chk("bad csum error held", DW'(load_error), DW'(1));
`endif

    // Reset after 10 data bytes: partial word discarded
    start_load(16'd1, 0);
    for (int k = 0; k < 10; k++) send(8'($urandom_range(0, 255)), 0);
    in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst in_ready", DW'(in_ready), DW'(0));
    chk("midrst wr_en", DW'(wr_en), DW'(0));
    chk("midrst wr_addr", DW'(wr_addr), DW'(0));
    chk("midrst wr_data", wr_data, DW'(0));
    chk("midrst word_count", DW'(word_count), DW'(0));
    chk("midrst load_done", DW'(load_done), DW'(0));
    chk("midrst engine_reset", DW'(engine_reset), DW'(1));
    repeat (20) cyc();
    start_load(16'd1, 0);
    send_word(16'd0, 1, 1'b0);
    finish_ok(16'd1);

    repeat (5) cyc();
    chk("scoreboard drained", DW'(exp_q.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
